rf_port_arbiter: RTL and testbench
==================================

# rf_port_arbiter

Sequencer and arbiter that shares the 8 x 16-bit register file between two requesters: the core datapath (port A) and the debug/load unit (port B). It grants one request at a time and drives the register file's single write/read port with registered signals. It sequences the file's one-cycle synchronous read, in which reads update only when the write enable is low, and returns read data or a write acknowledge to the granted requester.

## Interface
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (A always wins ties)
- CLK  in  1  rising-edge clock; one clock domain
- RST  in  1  synchronous, active-high reset
- A_REQ_VALID / B_REQ_VALID  in  1  request present
- A_REQ_READY / B_REQ_READY  out  1  request accepted this cycle (combinational from state and VALIDs)
- A_REQ_WR / B_REQ_WR  in  1  1 = write, 0 = read
- A_RS_ID, A_RT_ID / B_RS_ID, B_RT_ID  in  3  read source register IDs
- A_W_ID / B_W_ID  in  3  write destination register ID
- A_WDATA / B_WDATA  in  16  write data
- A_RSP_VALID / B_RSP_VALID  out  1  one-cycle response pulse (read data valid, or write done)
- A_RDATA1, A_RDATA2 / B_RDATA1, B_RDATA2  out  16  read results; shared registered value fanned to both ports
- RF_RS_ID, RF_RT_ID, RF_W_ID  out  3  to register file
- RF_WE  out  1  register file write enable
- RF_WDATA  out  16  register file write data
- RF_RDATA1, RF_RDATA2  in  16  register file read data, valid one cycle after a WE=0 edge

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE -> ISSUE on a grant.
  - ISSUE -> WAIT for a read.
  - ISSUE -> RESP for a write.
  - WAIT -> RESP.
  - RESP -> IDLE.
- READY outputs can be high only in IDLE. A handshake occurs when VALID and READY are high on the same edge. The granted command (WR, IDs, WDATA, owner) is latched at that edge.
- Arbitration in IDLE:
  - A_REQ_READY = A_REQ_VALID and (not B_REQ_VALID, or A preferred).
  - B_REQ_READY = B_REQ_VALID and (not A_REQ_VALID, or B preferred).
  - The two READYs are never high together.
- Preference:
  - PRIO_MODE=1: A is always preferred.
  - PRIO_MODE=0: a last-grant pointer sets preference to the port not granted last. The pointer updates only on a handshake. After reset, A is preferred.
- ISSUE drives the latched command onto RF_* (registered outputs):
  - Read: RF_WE=0.
  - Write: RF_WE=1 for exactly this cycle, with RF_W_ID and RF_WDATA.
- WAIT (reads only): RF_RDATA1/2 are sampled into the RDATA registers at the end of the cycle.
- RESP: owner's RSP_VALID=1 for one cycle, other port's RSP_VALID=0.
  - Read: RDATA holds the captured values.
  - Write: RDATA is unchanged.
- RF_WE is 0 in every state except ISSUE of a write. RF_* IDs and RF_WDATA hold their last driven value between requests.
- Requesters hold VALID and payload stable until READY. The arbiter does not check payload stability.
- No hazard logic is needed: commands are strictly serialized, so a read issued after a completed write always returns the new value.

## Timing
- Handshake at edge T. ISSUE is cycle T+1.
- Read: RF read issued during T+1, WAIT during T+2, RSP_VALID and RDATA in cycle T+3. Latency is 3.
- Write: RF_WE high during T+1, write commits at the end of T+1, RSP_VALID during T+2. Latency is 2.
- Next handshake: earliest at the end of T+4 after a read, or T+3 after a write.
- Peak throughput: 1 read per 4 cycles, 1 write per 3 cycles.
- Reset values: state=IDLE, both READY=0 while RST high, both RSP_VALID=0, RDATA=0, RF_WE=0, RF IDs=0, RF_WDATA=0, pointer prefers A.
- Reset mid-operation: the next cycle is IDLE with RF_WE=0. The in-flight request is dropped and gets no response. A write whose ISSUE cycle coincides with RST high is still performed by the register file in that cycle, because RF_WE was already registered.
- Simultaneous VALIDs with PRIO_MODE=0: grants alternate A, B, A, B, ...
- Simultaneous VALIDs with PRIO_MODE=1: B is starved while A stays valid; this is intended.

## Test plan
- Preload R3=123, R7=7. A reads RS=3, RT=7 -> A_RSP_VALID high exactly 3 cycles after the handshake with A_RDATA1=123, A_RDATA2=7. B_RSP_VALID stays 0.
- B writes R5=0xBEEF -> RF_WE high for one cycle with RF_W_ID=5, B_RSP_VALID 2 cycles after the handshake. Then A reads RS=5 -> A_RDATA1=0xBEEF.
- PRIO_MODE=0, A and B both continuously request reads -> grant order A, B, A, B. Each handshake is 4 cycles apart. Neither READY is asserted outside IDLE.
- PRIO_MODE=1, A and B both continuously valid for 5 A-requests -> 5 consecutive A grants, B_REQ_READY=0 throughout. B is granted the first IDLE cycle after A drops VALID.
- RST asserted during WAIT of an A read -> no A_RSP_VALID. All outputs hold reset values from the next cycle. After release, a B write completes normally.
- RST asserted in the ISSUE cycle of a write to R2=0x1111 -> R2 holds 0x1111. No response. A later read of R2 returns 0x1111.

Source files
------------

// File: rtl/rf_port_arbiter_if.sv
// One requester's command/response bundle toward the register-file arbiter.
// REQ_VALID/REQ_READY: a command transfers on the rising edge where both are high;
// the requester keeps REQ_VALID and payload steady until then. RSP_VALID is a one-cycle pulse.
interface rf_port_arbiter_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WR;
    logic [2:0]  RS_ID;
    logic [2:0]  RT_ID;
    logic [2:0]  W_ID;
    logic [15:0] WDATA;
    logic        RSP_VALID;
    logic [15:0] RDATA1;
    logic [15:0] RDATA2;

    modport master (
        output REQ_VALID, REQ_WR, RS_ID, RT_ID, W_ID, WDATA,
        input  REQ_READY, RSP_VALID, RDATA1, RDATA2
    );

    modport slave (
        input  REQ_VALID, REQ_WR, RS_ID, RT_ID, W_ID, WDATA,
        output REQ_READY, RSP_VALID, RDATA1, RDATA2
    );
endinterface

// File: rtl/rf_port_arbiter.sv
// Arbitrates the single register-file port between core (A) and debug/load (B),
// sequencing one command at a time: IDLE -> ISSUE -> (WAIT for reads) -> RESP.
module rf_port_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic               CLK,
    input  logic               RST,
    rf_port_arbiter_if.slave   a_if,
    rf_port_arbiter_if.slave   b_if,
    output logic [2:0]         RF_RS_ID,
    output logic [2:0]         RF_RT_ID,
    output logic [2:0]         RF_W_ID,
    output logic               RF_WE,
    output logic [15:0]        RF_WDATA,
    input  logic [15:0]        RF_RDATA1,
    input  logic [15:0]        RF_RDATA2,
    output logic [1:0]         state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        pref_b_q;
    logic        wr_q, owner_q, rf_we_q;
    logic [2:0]  rs_q, rt_q, w_q;
    logic [15:0] wdata_q, rdata1_q, rdata2_q;

    logic        a_pref, idle_ok, a_ready, b_ready, hs;
    logic        a_rsp, b_rsp;
    logic        wr_d;
    logic [2:0]  rs_d, rt_d, w_d;
    logic [15:0] wdata_d;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs) state_d = S_ISSUE;
            S_ISSUE: state_d = wr_q ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Preference flips to the port not granted last, unless A has fixed priority.
    always_comb begin
        a_pref  = (PRIO_MODE != 0) || !pref_b_q;
        idle_ok = (state_q == S_IDLE) && !RST;
        a_ready = idle_ok && a_if.REQ_VALID && (!b_if.REQ_VALID || a_pref);
        b_ready = idle_ok && b_if.REQ_VALID && (!a_if.REQ_VALID || !a_pref);
        hs      = a_ready || b_ready;
        a_rsp   = (state_q == S_RESP) && !owner_q;
        b_rsp   = (state_q == S_RESP) &&  owner_q;
    end

    always_comb begin
        wr_d    = b_ready ? b_if.REQ_WR : a_if.REQ_WR;
        rs_d    = b_ready ? b_if.RS_ID  : a_if.RS_ID;
        rt_d    = b_ready ? b_if.RT_ID  : a_if.RT_ID;
        w_d     = b_ready ? b_if.W_ID   : a_if.W_ID;
        wdata_d = b_ready ? b_if.WDATA  : a_if.WDATA;
    end

    // The command registers double as the RF drive, so ISSUE sees them one edge after the grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pref_b_q <= 1'b0;
            wr_q     <= 1'b0;
            owner_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            w_q      <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            if (hs) begin
                pref_b_q <= a_ready;
                owner_q  <= b_ready;
                wr_q     <= wr_d;
                rf_we_q  <= wr_d;
                rs_q     <= rs_d;
                rt_q     <= rt_d;
                w_q      <= w_d;
                wdata_q  <= wdata_d;
            end
            if (state_q == S_WAIT) begin
                rdata1_q <= RF_RDATA1;
                rdata2_q <= RF_RDATA2;
            end
        end
    end

    assign a_if.REQ_READY = a_ready;
    assign b_if.REQ_READY = b_ready;
    assign a_if.RSP_VALID = a_rsp;
    assign b_if.RSP_VALID = b_rsp;
    assign a_if.RDATA1    = rdata1_q;
    assign a_if.RDATA2    = rdata2_q;
    assign b_if.RDATA1    = rdata1_q;
    assign b_if.RDATA2    = rdata2_q;

    assign RF_RS_ID    = rs_q;
    assign RF_RT_ID    = rt_q;
    assign RF_W_ID     = w_q;
    assign RF_WE       = rf_we_q;
    assign RF_WDATA    = wdata_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: round-robin and fixed-priority instances share one command
// stream, each with its own register-file model and transaction-level reference.
module tb_rf_port_arbiter;

  typedef struct packed {
    logic        wr;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  w;
    logic [15:0] wd;
  } cmd_t;

  localparam logic [15:0] PRE [8] = '{16'h0a00, 16'h0b11, 16'h0c22, 16'd123,
                                      16'h0e44, 16'h0f55, 16'h1066, 16'd7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_port_arbiter_if a_if0 ();
  rf_port_arbiter_if b_if0 ();
  rf_port_arbiter_if a_if1 ();
  rf_port_arbiter_if b_if1 ();

  logic [2:0]  rf0_rs, rf0_rt, rf0_w, rf1_rs, rf1_rt, rf1_w;
  logic        rf0_we, rf1_we;
  logic [15:0] rf0_wd, rf1_wd;
  logic [15:0] rf0_rd1 = '0, rf0_rd2 = '0, rf1_rd1 = '0, rf1_rd2 = '0;
  logic [1:0]  dbg0, dbg1;
  logic [15:0] mem0 [8] = PRE;
  logic [15:0] mem1 [8] = PRE;

  rf_port_arbiter #(.PRIO_MODE(0)) u_rr (
    .CLK(clk), .RST(rst), .a_if(a_if0), .b_if(b_if0),
    .RF_RS_ID(rf0_rs), .RF_RT_ID(rf0_rt), .RF_W_ID(rf0_w), .RF_WE(rf0_we),
    .RF_WDATA(rf0_wd), .RF_RDATA1(rf0_rd1), .RF_RDATA2(rf0_rd2), .state_dbg_o(dbg0)
  );

  rf_port_arbiter #(.PRIO_MODE(1)) u_fp (
    .CLK(clk), .RST(rst), .a_if(a_if1), .b_if(b_if1),
    .RF_RS_ID(rf1_rs), .RF_RT_ID(rf1_rt), .RF_W_ID(rf1_w), .RF_WE(rf1_we),
    .RF_WDATA(rf1_wd), .RF_RDATA1(rf1_rd1), .RF_RDATA2(rf1_rd2), .state_dbg_o(dbg1)
  );

  // register file: write when WE, otherwise registered read
  always @(posedge clk) begin
    if (rf0_we) mem0[rf0_w] <= rf0_wd;
    else begin
      rf0_rd1 <= mem0[rf0_rs];
      rf0_rd2 <= mem0[rf0_rt];
    end
  end

  always @(posedge clk) begin
    if (rf1_we) mem1[rf1_w] <= rf1_wd;
    else begin
      rf1_rd1 <= mem1[rf1_rs];
      rf1_rd2 <= mem1[rf1_rt];
    end
  end

  // ---------------- bench state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  cmd_t la[$];
  cmd_t lb[$];
  int   ia[2], ib[2];
  logic a_valid[2], b_valid[2];
  cmd_t a_cmd[2], b_cmd[2];

  logic        o_ra[2], o_rb[2], o_sa[2], o_sb[2], o_we[2];
  logic [15:0] o_ad1[2], o_ad2[2], o_bd1[2], o_bd2[2], o_wd[2];
  logic [2:0]  o_rs[2], o_rt[2], o_w[2];
  logic [1:0]  o_st[2];

  // reference: at most one command in flight per instance
  bit          infl[2];
  int          hs_cyc[2];
  cmd_t        t_cmd[2];
  bit          t_own[2];
  logic [15:0] t_d1[2], t_d2[2];
  logic [15:0] rd1_exp[2], rd2_exp[2];
  bit          pref_b[2];
  logic [15:0] ref_mem [2][8];
  bit          arm_wait_rst, arm_issue_rst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic cmd_t mk_rd(input logic [2:0] rs, input logic [2:0] rt);
    cmd_t c;
    c = '0;
    c.rs = rs;
    c.rt = rt;
    return c;
  endfunction

  function automatic cmd_t mk_wr(input logic [2:0] w, input logic [15:0] wd);
    cmd_t c;
    c = '0;
    c.wr = 1'b1;
    c.w  = w;
    c.wd = wd;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.wr = 1'($urandom_range(0, 1));
    c.rs = 3'($urandom_range(0, 7));
    c.rt = 3'($urandom_range(0, 7));
    c.w  = 3'($urandom_range(0, 7));
    c.wd = 16'($urandom_range(0, 65535));
    return c;
  endfunction

  // read occupies grant+1..grant+3, write grant+1..grant+2
  function automatic bit busy(input int k, input int n);
    int d;
    d = n - hs_cyc[k];
    return infl[k] && (d <= (t_cmd[k].wr ? 2 : 3));
  endfunction

  function automatic bit all_done();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 2; k++)
      if (ia[k] != la.size() || ib[k] != lb.size() || busy(k, cyc)) ok = 1'b0;
    return ok;
  endfunction

  task automatic drive_inputs();
    {a_if0.REQ_VALID, a_if0.REQ_WR, a_if0.RS_ID, a_if0.RT_ID, a_if0.W_ID, a_if0.WDATA} = {a_valid[0], a_cmd[0]};
    {b_if0.REQ_VALID, b_if0.REQ_WR, b_if0.RS_ID, b_if0.RT_ID, b_if0.W_ID, b_if0.WDATA} = {b_valid[0], b_cmd[0]};
    {a_if1.REQ_VALID, a_if1.REQ_WR, a_if1.RS_ID, a_if1.RT_ID, a_if1.W_ID, a_if1.WDATA} = {a_valid[1], a_cmd[1]};
    {b_if1.REQ_VALID, b_if1.REQ_WR, b_if1.RS_ID, b_if1.RT_ID, b_if1.W_ID, b_if1.WDATA} = {b_valid[1], b_cmd[1]};
  endtask

  task automatic sample_outputs();
    {o_ra[0], o_sa[0], o_ad1[0], o_ad2[0]} = {a_if0.REQ_READY, a_if0.RSP_VALID, a_if0.RDATA1, a_if0.RDATA2};
    {o_rb[0], o_sb[0], o_bd1[0], o_bd2[0]} = {b_if0.REQ_READY, b_if0.RSP_VALID, b_if0.RDATA1, b_if0.RDATA2};
    {o_ra[1], o_sa[1], o_ad1[1], o_ad2[1]} = {a_if1.REQ_READY, a_if1.RSP_VALID, a_if1.RDATA1, a_if1.RDATA2};
    {o_rb[1], o_sb[1], o_bd1[1], o_bd2[1]} = {b_if1.REQ_READY, b_if1.RSP_VALID, b_if1.RDATA1, b_if1.RDATA2};
    {o_we[0], o_rs[0], o_rt[0], o_w[0], o_wd[0], o_st[0]} = {rf0_we, rf0_rs, rf0_rt, rf0_w, rf0_wd, dbg0};
    {o_we[1], o_rs[1], o_rt[1], o_w[1], o_wd[1], o_st[1]} = {rf1_we, rf1_rs, rf1_rt, rf1_w, rf1_wd, dbg1};
  endtask

  // compare cycle `cyc` of instance k, then advance the reference past the closing edge
  task automatic model_cycle(input int k);
    int   d;
    bit   bz, ap, era, erb, ewe, esa, esb;
    cmd_t c;
    d   = cyc - hs_cyc[k];
    bz  = busy(k, cyc);
    ap  = (k == 1) || !pref_b[k];
    era = !rst && !bz && a_valid[k] && (!b_valid[k] || ap);
    erb = !rst && !bz && b_valid[k] && (!a_valid[k] || !ap);
    ewe = infl[k] && d == 1 && t_cmd[k].wr;
    esa = infl[k] && d == (t_cmd[k].wr ? 2 : 3) && !t_own[k];
    esb = infl[k] && d == (t_cmd[k].wr ? 2 : 3) &&  t_own[k];
    check_eq($sformatf("i%0d_a_ready", k), o_ra[k], era);
    check_eq($sformatf("i%0d_b_ready", k), o_rb[k], erb);
    check_eq($sformatf("i%0d_a_rsp", k), o_sa[k], esa);
    check_eq($sformatf("i%0d_b_rsp", k), o_sb[k], esb);
    check_eq($sformatf("i%0d_rf_we", k), o_we[k], ewe);
    check_eq($sformatf("i%0d_idle", k), (o_st[k] == 2'd0), !bz);
    check_eq($sformatf("i%0d_a_rdata", k), {o_ad1[k], o_ad2[k]}, {rd1_exp[k], rd2_exp[k]});
    check_eq($sformatf("i%0d_b_rdata", k), {o_bd1[k], o_bd2[k]}, {rd1_exp[k], rd2_exp[k]});
    if (infl[k] && d == 1) begin
      if (t_cmd[k].wr)
        check_eq($sformatf("i%0d_rf_write", k), {o_w[k], o_wd[k]}, {t_cmd[k].w, t_cmd[k].wd});
      else
        check_eq($sformatf("i%0d_rf_read_ids", k), {o_rs[k], o_rt[k]}, {t_cmd[k].rs, t_cmd[k].rt});
    end
    if (rst) begin
      infl[k]    = 1'b0;
      rd1_exp[k] = '0;
      rd2_exp[k] = '0;
      pref_b[k]  = 1'b0;
    end else begin
      if (infl[k] && !t_cmd[k].wr && d == 2) begin
        rd1_exp[k] = t_d1[k];
        rd2_exp[k] = t_d2[k];
      end
      if (era || erb) begin
        c         = erb ? b_cmd[k] : a_cmd[k];
        t_cmd[k]  = c;
        t_own[k]  = erb;
        hs_cyc[k] = cyc;
        infl[k]   = 1'b1;
        pref_b[k] = era;
        if (c.wr) ref_mem[k][c.w] = c.wd;
        else begin
          t_d1[k] = ref_mem[k][c.rs];
          t_d2[k] = ref_mem[k][c.rt];
        end
      end
    end
  endtask

  task automatic step(input bit rst_next);
    @(negedge clk);
    sample_outputs();
    for (int k = 0; k < 2; k++) model_cycle(k);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (a_valid[k] && o_ra[k]) ia[k]++;
      if (b_valid[k] && o_rb[k]) ib[k]++;
      a_valid[k] = (ia[k] < la.size());
      b_valid[k] = (ib[k] < lb.size());
      if (a_valid[k]) a_cmd[k] = la[ia[k]];
      if (b_valid[k]) b_cmd[k] = lb[ib[k]];
    end
    rst = rst_next;
    if (arm_wait_rst && infl[0] && !t_cmd[0].wr && !t_own[0] && (cyc - hs_cyc[0]) == 2) begin
      rst = 1'b1;
      arm_wait_rst = 1'b0;
    end
    if (arm_issue_rst && infl[0] && t_cmd[0].wr && (cyc - hs_cyc[0]) == 1) begin
      rst = 1'b1;
      arm_issue_rst = 1'b0;
    end
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  initial begin
    int guard;
    int lo_a, lo_b;
    for (int k = 0; k < 2; k++) begin
      ia[k] = 0; ib[k] = 0;
      a_valid[k] = 1'b0; b_valid[k] = 1'b0;
      a_cmd[k] = '0; b_cmd[k] = '0;
      infl[k] = 1'b0; hs_cyc[k] = 0; pref_b[k] = 1'b0;
      rd1_exp[k] = '0; rd2_exp[k] = '0;
      for (int r = 0; r < 8; r++) ref_mem[k][r] = PRE[r];
    end
    arm_wait_rst  = 1'b0;
    arm_issue_rst = 1'b0;
    rst = 1'b1;
    drive_inputs();

    step(1'b1);
    step(1'b1);
    step(1'b0);

    la.push_back(mk_rd(3'd3, 3'd7));
    run(8);
    lb.push_back(mk_wr(3'd5, 16'hBEEF));
    run(6);
    la.push_back(mk_rd(3'd5, 3'd0));
    run(8);

    for (int i = 0; i < 4; i++) begin
      la.push_back(mk_rd(3'(i), 3'(i + 1)));
      lb.push_back(mk_rd(3'(i + 4), 3'(i + 2)));
    end
    run(40);

    for (int i = 0; i < 5; i++) la.push_back(mk_rd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))));
    lb.push_back(mk_rd(3'd2, 3'd3));
    run(60);

    arm_wait_rst = 1'b1;
    la.push_back(mk_rd(3'd1, 3'd2));
    run(12);
    lb.push_back(mk_wr(3'd4, 16'h4444));
    run(8);

    arm_issue_rst = 1'b1;
    la.push_back(mk_wr(3'd2, 16'h1111));
    run(10);
    lb.push_back(mk_rd(3'd2, 3'd4));
    run(8);
    check_eq("i0_r2_after_reset_write", mem0[2], 16'h1111);
    check_eq("i1_r2_after_reset_write", mem1[2], 16'h1111);

    arm_wait_rst  = 1'b0;
    arm_issue_rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      lo_a = (ia[0] < ia[1]) ? ia[0] : ia[1];
      lo_b = (ib[0] < ib[1]) ? ib[0] : ib[1];
      if (la.size() - lo_a < 3 && $urandom_range(0, 2) == 0) la.push_back(rand_cmd());
      if (lb.size() - lo_b < 3 && $urandom_range(0, 2) == 0) lb.push_back(rand_cmd());
      step($urandom_range(0, 99) == 0);
    end

    guard = 0;
    while (!all_done() && guard < 300) begin
      step(1'b0);
      guard++;
    end
    check_eq("drain_done", all_done(), 1'b1);
    step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
